// File: rtl/accel_pkg.sv
// Shared opcodes, response bytes and command-decoder FSM states for the accelerator host link.
package accel_pkg;

  localparam logic [7:0] OP_START = 8'h01;
  localparam logic [7:0] OP_DIMS  = 8'h02;
  localparam logic [7:0] OP_WR_A  = 8'h10;
  localparam logic [7:0] OP_WR_B  = 8'h11;

  localparam logic [7:0] RESP_ACK = 8'hAA;
  localparam logic [7:0] RESP_NAK = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    EXEC,
    RESP
  } cmd_state_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_START) || (op == OP_DIMS) || (op == OP_WR_A) || (op == OP_WR_B);
  endfunction

endpackage

// File: rtl/pkt_timeout.sv
// Inter-byte idle watchdog: expired is high on the LIMIT-th consecutive enabled cycle.
// Combinational expired, registered count; clear dominates enable.
module pkt_timeout #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_packet_decoder.sv
// UART command decoder: opcode + addr(2, LE) + data(4, LE) [+ XOR checksum when CMD_CHECKSUM_EN].
// Strobes 2 cycles after the final byte, response 1 cycle later and held until tx_ready; rx has no backpressure.
module cmd_packet_decoder
  import accel_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_wr_en,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              start,
  output logic              dims_wr,
  output logic [DATA_W-1:0] dims_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        err_cnt
);

`ifdef CMD_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  cmd_state_t  state, state_nxt;
  logic [7:0]  opcode_q;
  logic [2:0]  byte_cnt;
  logic [47:0] payload_q;
  logic        pkt_ok;
  logic        to_clear, to_enable, to_expired;
  logic        overrun, bad_pkt, err_inc;

`ifdef CMD_CHECKSUM_EN
  // Running XOR over every byte including the checksum: a clean packet folds to zero.
  logic [7:0] csum_q;
  assign pkt_ok = op_known(opcode_q) && (csum_q == 8'h00);
`else
  assign pkt_ok = op_known(opcode_q);
`endif

  assign tx_valid  = (state == RESP);
  assign to_enable = (state == PAYLOAD) && !rx_valid;
  assign to_clear  = (state != PAYLOAD) || rx_valid;
  assign overrun   = rx_valid && ((state == CHECK) || (state == EXEC) || (state == RESP));
  assign bad_pkt   = (state == CHECK) && !pkt_ok;
  assign err_inc   = overrun || bad_pkt || to_expired;

  pkt_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_valid) state_nxt = PAYLOAD;
      PAYLOAD: begin
        if (rx_valid && (byte_cnt == LAST_IDX)) begin
          state_nxt = CHECK;
        end else if (to_expired) begin
          state_nxt = IDLE;
        end
      end
      CHECK:   state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q    <= '0;
      byte_cnt    <= '0;
      payload_q   <= '0;
`ifdef CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
      mem_wr_en   <= 1'b0;
      mem_sel     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      start       <= 1'b0;
      dims_wr     <= 1'b0;
      dims_data   <= '0;
      tx_data     <= '0;
      err_cnt     <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      start     <= 1'b0;
      dims_wr   <= 1'b0;

      if ((state == IDLE) && rx_valid) begin
        opcode_q <= rx_data;
        byte_cnt <= '0;
`ifdef CMD_CHECKSUM_EN
        csum_q   <= rx_data;
`endif
      end

      if ((state == PAYLOAD) && rx_valid) begin
        byte_cnt <= byte_cnt + 3'd1;
`ifdef CMD_CHECKSUM_EN
        csum_q   <= csum_q ^ rx_data;
`endif
        // Little-endian shift: after six bytes addr sits in [15:0], data in [47:16].
        if (byte_cnt < 3'd6) begin
          payload_q <= {rx_data, payload_q[47:8]};
        end
      end

      // Strobes are registered here so they appear during the EXEC cycle.
      if (state == CHECK) begin
        tx_data <= pkt_ok ? RESP_ACK : RESP_NAK;
        if (pkt_ok) begin
          case (opcode_q)
            OP_START: start <= 1'b1;
            OP_DIMS: begin
              dims_wr   <= 1'b1;
              dims_data <= DATA_W'(payload_q[47:16]);
            end
            OP_WR_A, OP_WR_B: begin
              mem_wr_en   <= 1'b1;
              mem_sel     <= (opcode_q == OP_WR_B);
              mem_addr    <= ADDR_W'(payload_q[15:0]);
              mem_wr_data <= DATA_W'(payload_q[47:16]);
            end
            default: ;
          endcase
        end
      end

      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_packet_decoder.sv
// Directed scenarios for cmd_packet_decoder with a strobe/response scoreboard.
module tb_cmd_packet_decoder;

`ifdef CMD_CHECKSUM_EN
  localparam int PKT_LEN = 8;
`else
  localparam int PKT_LEN = 7;
`endif

  typedef struct packed {
    logic [1:0]  kind;  // 0 start, 1 dims, 2 mem write
    logic        sel;
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_wr_en;
  logic        mem_sel;
  logic [15:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        start;
  logic        dims_wr;
  logic [31:0] dims_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  ev_t        exp_ev[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_err = 8'h00;

  ev_t         mon_e;
  logic [51:0] mon_obs, mon_req;
  logic [7:0]  mon_b;

  cmd_packet_decoder #(
    .ADDR_W(16),
    .DATA_W(32),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_wr_en  (mem_wr_en),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .start      (start),
    .dims_wr    (dims_wr),
    .dims_data  (dims_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every strobe and every response handshake must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en || start || dims_wr) begin
        n_cmp++;
        if (exp_ev.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: got start=%b dims_wr=%b mem_wr_en=%b, required no strobe",
                   start, dims_wr, mem_wr_en);
        end else begin
          mon_e   = exp_ev.pop_front();
          mon_obs = {start, dims_wr, mem_wr_en,
                     mem_wr_en ? mem_sel : 1'b0,
                     mem_wr_en ? mem_addr : 16'h0,
                     mem_wr_en ? mem_wr_data : (dims_wr ? dims_data : 32'h0)};
          mon_req = {mon_e.kind == 2'd0, mon_e.kind == 2'd1, mon_e.kind == 2'd2,
                     mon_e.sel, mon_e.addr, mon_e.data};
          if (mon_obs !== mon_req) begin
            n_bad++;
            $display("FAIL strobe_fields: got %h, required %h", mon_obs, mon_req);
          end
        end
      end
      if (tx_valid && tx_ready) begin
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_tx: got tx_data=%h, required no response", tx_data);
        end else begin
          mon_b = exp_tx.pop_front();
          if (tx_data !== mon_b) begin
            n_bad++;
            $display("FAIL tx_data: got %h, required %h", tx_data, mon_b);
          end
        end
      end
    end
  end

  task automatic bump_err;
    exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
  endtask

  // Caller is #1 after a rising edge; the byte is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [15:0] addr,
                          input logic [31:0] data, input bit bad_csum);
    logic [7:0] b [8];
    logic [7:0] x;
    bit ok;
    ev_t e;
    b[0] = op;          b[1] = addr[7:0];    b[2] = addr[15:8];
    b[3] = data[7:0];   b[4] = data[15:8];   b[5] = data[23:16];  b[6] = data[31:24];
    x = 8'h00;
    for (int i = 0; i < 7; i++) x ^= b[i];
    b[7] = bad_csum ? (x ^ 8'h01) : x;
    ok = (op == 8'h01) || (op == 8'h02) || (op == 8'h10) || (op == 8'h11);
`ifdef CMD_CHECKSUM_EN
    ok = ok && !bad_csum;
`endif
    if (ok) begin
      e.kind = (op == 8'h01) ? 2'd0 : (op == 8'h02) ? 2'd1 : 2'd2;
      e.sel  = (op == 8'h11);
      e.addr = (e.kind == 2'd2) ? addr : 16'h0;
      e.data = (e.kind == 2'd0) ? 32'h0 : data;
      exp_ev.push_back(e);
      exp_tx.push_back(8'hAA);
    end else begin
      exp_tx.push_back(8'h55);
      bump_err();
    end
    for (int i = 0; i < PKT_LEN; i++) send_byte(b[i]);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_ev.size() == 0 && exp_tx.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if ({mem_wr_en, mem_sel, start, dims_wr, tx_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b, required 00000", {mem_wr_en, mem_sel, start, dims_wr, tx_valid}); end
    n_cmp++; if (mem_addr !== 16'h0 || mem_wr_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_mem: got %h/%h, required 0/0", mem_addr, mem_wr_data); end
    n_cmp++; if (dims_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_dims: got %h, required 0", dims_data); end
    n_cmp++; if (tx_data !== 8'h0) begin
      n_bad++; $display("FAIL reset_tx_data: got %h, required 0", tx_data); end
    n_cmp++; if (err_cnt !== 8'h0) begin
      n_bad++; $display("FAIL reset_err_cnt: got %h, required 0", err_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_write_a;
    bit ok;
    send_pkt(8'h10, 16'h0005, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    n_cmp++; if (mem_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL wr_early: got mem_wr_en=%b one cycle after last byte, required 0", mem_wr_en); end
    @(negedge clk);
    n_cmp++; if (mem_wr_en !== 1'b1) begin
      n_bad++; $display("FAIL wr_latency: got mem_wr_en=%b two cycles after last byte, required 1", mem_wr_en); end
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b1 || mem_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL tx_latency: got tx_valid=%b mem_wr_en=%b, required 1 0", tx_valid, mem_wr_en); end
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL write_a_drain: got pending, required drained"); end
    n_cmp++; if (mem_addr !== 16'h0005 || mem_wr_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL write_a_hold: got %h/%h, required 0005/deadbeef", mem_addr, mem_wr_data); end
  endtask

  task automatic test_start_backpressure;
    bit ok;
    tx_ready = 1'b0;
    send_pkt(8'h01, 16'h1111, 32'h22222222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin
        n_bad++; $display("FAIL resp_hold[%0d]: got tx_valid=%b tx_data=%h, required 1 aa", i, tx_valid, tx_data); end
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL resp_release: got tx_valid=%b, required 0", tx_valid); end
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL start_drain: got pending, required drained"); end
  endtask

  task automatic test_bad_opcode;
    bit ok;
    send_pkt(8'h7F, 16'h0001, 32'h00000002, 1'b0);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL nak_drain: got pending, required drained"); end
    n_cmp++; if (err_cnt !== exp_err || err_cnt !== 8'h01) begin
      n_bad++; $display("FAIL nak_err_cnt: got %h, required %h", err_cnt, exp_err); end
  endtask

  task automatic test_timeout;
    bit ok;
    send_byte(8'h10);
    send_byte(8'h34);
    repeat (49) @(posedge clk);
    #1;
    send_byte(8'h12);
    n_cmp++; if (err_cnt !== exp_err) begin
      n_bad++; $display("FAIL timeout_boundary_byte: got err_cnt=%h, required %h", err_cnt, exp_err); end
    repeat (49) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++; if (err_cnt !== exp_err) begin
      n_bad++; $display("FAIL timeout_early: got err_cnt=%h, required %h", err_cnt, exp_err); end
    @(negedge clk);
    bump_err();
    n_cmp++; if (err_cnt !== exp_err) begin
      n_bad++; $display("FAIL timeout_err: got err_cnt=%h, required %h", err_cnt, exp_err); end
    n_cmp++; if (tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_no_resp: got tx_valid=%b, required 0", tx_valid); end
    @(posedge clk);
    #1;
    send_pkt(8'h11, 16'h0ABC, 32'hCAFEF00D, 1'b0);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL write_b_drain: got pending, required drained"); end
    n_cmp++; if (mem_sel !== 1'b1 || mem_addr !== 16'h0ABC) begin
      n_bad++; $display("FAIL write_b_hold: got sel=%b addr=%h, required 1 0abc", mem_sel, mem_addr); end
  endtask

  task automatic test_overrun;
    bit ok;
    // Bad opcode and an overrun byte in the same CHECK cycle add a single error.
    send_pkt(8'h33, 16'h0000, 32'h0, 1'b0);
    send_byte(8'h99);
    wait_drain(ok);
    n_cmp++; if (!ok || err_cnt !== exp_err) begin
      n_bad++; $display("FAIL overrun_same_cycle: got err_cnt=%h, required %h", err_cnt, exp_err); end
    tx_ready = 1'b0;
    send_pkt(8'h01, 16'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h5A);
    bump_err();
    tx_ready = 1'b1;
    wait_drain(ok);
    n_cmp++; if (!ok || err_cnt !== exp_err) begin
      n_bad++; $display("FAIL overrun_resp: got err_cnt=%h, required %h", err_cnt, exp_err); end
  endtask

  task automatic test_checksum_saturate;
    bit ok;
`ifdef CMD_CHECKSUM_EN
    send_pkt(8'h10, 16'h0077, 32'h01020304, 1'b1);
    wait_drain(ok);
    n_cmp++; if (!ok || err_cnt !== exp_err || mem_addr !== 16'h0ABC) begin
      n_bad++; $display("FAIL bad_checksum: got err_cnt=%h addr=%h, required %h 0abc", err_cnt, mem_addr, exp_err); end
`endif
    for (int i = 0; i < 300; i++) begin
`ifdef CMD_CHECKSUM_EN
      send_pkt(8'h10, 16'(i), 32'(i), 1'b1);
`else
      send_pkt(8'h7F, 16'(i), 32'(i), 1'b0);
`endif
      repeat (4) @(posedge clk);
      #1;
    end
    wait_drain(ok);
    n_cmp++; if (!ok || err_cnt !== exp_err || err_cnt !== 8'hFF) begin
      n_bad++; $display("FAIL err_saturate: got err_cnt=%h, required ff", err_cnt); end
  endtask

  task automatic test_reset_midpacket;
    bit ok;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hEE);
    rst = 1'b1;
    #2;
    exp_err = 8'h00;
    n_cmp++; if (err_cnt !== 8'h00 || tx_data !== 8'h00) begin
      n_bad++; $display("FAIL async_reset: got err_cnt=%h tx_data=%h, required 00 00", err_cnt, tx_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_pkt(8'h02, 16'h0000, 32'h12345678, 1'b0);
    wait_drain(ok);
    n_cmp++; if (!ok || dims_data !== 32'h12345678) begin
      n_bad++; $display("FAIL dims_after_reset: got %h, required 12345678", dims_data); end
    n_cmp++; if (err_cnt !== exp_err) begin
      n_bad++; $display("FAIL err_after_reset: got %h, required %h", err_cnt, exp_err); end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    test_reset();
    test_write_a();
    test_start_backpressure();
    test_bad_opcode();
    test_timeout();
    test_overrun();
    test_checksum_saturate();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got no completion by 500000ns, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
